// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller in front of a dual-port RAM: port 1 writes, port 2 reads, with a 2-entry
// prefetch buffer so pops run at one word per clock. Optional error flags: DPRAM_FIFO_CTRL_ERR_EN.
module dpram_fifo_ctrl #(
    parameter int unsigned AddrWidth = 4,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Depth     = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 push_valid,
    output logic                 push_ready,
    input  logic [DataWidth-1:0] push_data,
    output logic                 pop_valid,
    input  logic                 pop_ready,
    output logic [DataWidth-1:0] pop_data,
    output logic [AddrWidth+1:0] level,
    output logic                 ram_cs,
    output logic [AddrWidth-1:0] ram_addr1,
    output logic [DataWidth-1:0] ram_wrdata1,
    output logic                 ram_wr1,
    output logic                 ram_rd1,
    output logic [AddrWidth-1:0] ram_addr2,
    output logic [DataWidth-1:0] ram_wrdata2,
    output logic                 ram_wr2,
    output logic                 ram_rd2,
`ifdef DPRAM_FIFO_CTRL_ERR_EN
    input  logic                 err_clr,
    output logic                 err_ovf,
    output logic                 err_udf,
`endif
    input  logic [DataWidth-1:0] ram_rddata2
);

    localparam logic [AddrWidth:0] DepthCnt = (AddrWidth+1)'(Depth);

    logic [AddrWidth:0]   wr_ptr_q, rd_ptr_q, ram_count;
    logic                 inflight_q;
    logic [1:0]           buf_count_q, buf_count_d;
    logic [DataWidth-1:0] buf0_q, buf1_q, buf0_d, buf1_d;
    logic                 push_fire, pop_fire, fetch;
    logic [2:0]           occ;

    assign ram_count  = wr_ptr_q - rd_ptr_q;
    assign push_ready = rstn & (ram_count != DepthCnt);
    assign push_fire  = push_valid & push_ready;
    assign pop_valid  = (buf_count_q != 2'd0);
    assign pop_fire   = pop_valid & pop_ready;
    assign pop_data   = buf0_q;

    // Buffer slots that will be occupied after this edge if no new fetch is issued.
    assign occ   = {1'b0, buf_count_q} + {2'b00, inflight_q} - {2'b00, pop_fire};
    assign fetch = rstn & (ram_count != '0) & (occ < 3'd2);

    assign level = {1'b0, ram_count} + {{(AddrWidth+1){1'b0}}, inflight_q}
                 + {{AddrWidth{1'b0}}, buf_count_q};

    // The RAM is kept enabled whenever the controller is out of reset.
    assign ram_cs      = rstn;
    assign ram_rd2     = rstn;
    assign ram_addr1   = wr_ptr_q[AddrWidth-1:0];
    assign ram_wrdata1 = push_data;
    assign ram_wr1     = push_fire;
    assign ram_rd1     = 1'b0;
    assign ram_addr2   = rd_ptr_q[AddrWidth-1:0];
    assign ram_wrdata2 = '0;
    assign ram_wr2     = 1'b0;

    always_comb begin
        buf0_d      = buf0_q;
        buf1_d      = buf1_q;
        buf_count_d = buf_count_q;
        if (pop_fire) begin
            buf0_d      = buf1_q;
            buf_count_d = buf_count_d - 2'd1;
        end
        if (inflight_q) begin
            if (buf_count_d == 2'd0) begin
                buf0_d = ram_rddata2;
            end else begin
                buf1_d = ram_rddata2;
            end
            buf_count_d = buf_count_d + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            inflight_q  <= 1'b0;
            buf_count_q <= 2'd0;
        end else begin
            wr_ptr_q    <= wr_ptr_q + {{AddrWidth{1'b0}}, push_fire};
            rd_ptr_q    <= rd_ptr_q + {{AddrWidth{1'b0}}, fetch};
            inflight_q  <= fetch;
            buf_count_q <= buf_count_d;
        end
    end

    // Data slots need no reset; validity is carried by buf_count_q.
    always_ff @(posedge clk) begin
        buf0_q <= buf0_d;
        buf1_q <= buf1_d;
    end

`ifdef DPRAM_FIFO_CTRL_ERR_EN
    logic err_ovf_q, err_udf_q;
    logic ovf_set, udf_set;

    assign ovf_set = push_valid & ~push_ready;
    assign udf_set = pop_ready & ~pop_valid & (level == '0);
    assign err_ovf = err_ovf_q;
    assign err_udf = err_udf_q;

    // Set wins over clear when both occur in the same cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            err_ovf_q <= ovf_set | (err_ovf_q & ~err_clr);
            err_udf_q <= udf_set | (err_udf_q & ~err_clr);
        end
    end
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Self-checking bench for dpram_fifo_ctrl: directed steps plus random traffic against a
// queue-based reference model; includes a behavioural dual-port RAM.
module tb_dpram_fifo_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rstn;
    logic          push_valid;
    logic          push_ready;
    logic [DW-1:0] push_data;
    logic          pop_valid;
    logic          pop_ready;
    logic [DW-1:0] pop_data;
    logic [AW+1:0] level;
    logic          ram_cs;
    logic [AW-1:0] ram_addr1;
    logic [DW-1:0] ram_wrdata1;
    logic          ram_wr1;
    logic          ram_rd1;
    logic [AW-1:0] ram_addr2;
    logic [DW-1:0] ram_wrdata2;
    logic          ram_wr2;
    logic          ram_rd2;
    logic [DW-1:0] ram_rddata2;
`ifdef DPRAM_FIFO_CTRL_ERR_EN
    logic          err_clr;
    logic          err_ovf;
    logic          err_udf;
    bit            clr_req;
`endif

    dpram_fifo_ctrl #(
        .AddrWidth(AW),
        .DataWidth(DW),
        .Depth    (DEPTH)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_data  (push_data),
        .pop_valid  (pop_valid),
        .pop_ready  (pop_ready),
        .pop_data   (pop_data),
        .level      (level),
        .ram_cs     (ram_cs),
        .ram_addr1  (ram_addr1),
        .ram_wrdata1(ram_wrdata1),
        .ram_wr1    (ram_wr1),
        .ram_rd1    (ram_rd1),
        .ram_addr2  (ram_addr2),
        .ram_wrdata2(ram_wrdata2),
        .ram_wr2    (ram_wr2),
        .ram_rd2    (ram_rd2),
`ifdef DPRAM_FIFO_CTRL_ERR_EN
        .err_clr    (err_clr),
        .err_ovf    (err_ovf),
        .err_udf    (err_udf),
`endif
        .ram_rddata2(ram_rddata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Dual-port RAM: registered read on port 2, write on port 1.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_cs && ram_wr1) mem[ram_addr1] <= ram_wrdata1;
        if (ram_cs && ram_rd2) ram_rddata2 <= mem[ram_addr2];
    end

    int checks   = 0;
    int failures = 0;

    // Reference model: words in RAM, the word being fetched, and the prefetch buffer.
    logic [DW-1:0] m_ram[$];
    logic [DW-1:0] m_buf[$];
    bit            m_inf = 0;
    logic [DW-1:0] m_infw;
    logic [DW-1:0] popped[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cycle(input logic pv, input logic [DW-1:0] pd, input logic pr, input logic rn,
                         input bit do_chk);
        bit exp_pr, mpop, missue;
        push_valid = pv;
        push_data  = pd;
        pop_ready  = pr;
        rstn       = rn;
`ifdef DPRAM_FIFO_CTRL_ERR_EN
        err_clr    = clr_req;
`endif
        #1;
        exp_pr = rn && (m_ram.size() != DEPTH);
        if (do_chk) begin
            chk("push_ready", 32'(push_ready), 32'(exp_pr));
            chk("pop_valid", 32'(pop_valid), 32'(m_buf.size() != 0));
            if (m_buf.size() != 0) chk("pop_data", pop_data, m_buf[0]);
            chk("level", 32'(level), 32'(m_ram.size() + int'(m_inf) + m_buf.size()));
            chk("ram_wr1", 32'(ram_wr1), 32'(pv && exp_pr));
            chk("ram_cs", 32'(ram_cs), 32'(rn));
            chk("ram_rd2", 32'(ram_rd2), 32'(rn));
            chk("ram_port_ties", {ram_wrdata2[31:2], ram_wr2, ram_rd1}, 32'h0);
        end
        if (rn && pop_valid && pr) popped.push_back(pop_data);
        mpop   = (m_buf.size() != 0) && pr;
        missue = (m_ram.size() != 0) && (m_buf.size() + int'(m_inf) - int'(mpop) < 2);
        @(posedge clk);
        if (!rn) begin
            m_ram.delete();
            m_buf.delete();
            m_inf = 0;
        end else begin
            if (mpop) void'(m_buf.pop_front());
            if (m_inf) m_buf.push_back(m_infw);
            m_inf = missue;
            if (missue) m_infw = m_ram.pop_front();
            if (pv && exp_pr) m_ram.push_back(pd);
        end
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gaps;
        int pb, rb;
`ifdef DPRAM_FIFO_CTRL_ERR_EN
        clr_req = 0;
`endif
        // Reset held with push_valid asserted.
        cycle(1, 32'h0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, $urandom, 0, 0, 1);
        cycle(0, 32'h0, 0, 1, 1);
        chk("release_push_ready", 32'(push_ready), 32'd1);
        chk("release_ram_cs", 32'(ram_cs), 32'd1);

        // Single word: visible two edges after acceptance.
        cycle(1, 32'hA5A5_0001, 0, 1, 1);
        cycle(0, 32'h0, 0, 1, 1);
        chk("single_early", 32'(pop_valid), 32'd0);
        cycle(0, 32'h0, 0, 1, 1);
        chk("single_valid", 32'(pop_valid), 32'd1);
        chk("single_data", pop_data, 32'hA5A5_0001);
        chk("single_level", 32'(level), 32'd1);
        cycle(0, 32'h0, 1, 1, 1);
        chk("single_pop_level", 32'(level), 32'd0);
        chk("single_pop_valid", 32'(pop_valid), 32'd0);

        // Fill to capacity Depth+2, then drain back-to-back.
        for (int i = 0; i < 20; i++) cycle(1, 32'(i), 0, 1, 1);
        chk("fill_level", 32'(level), 32'(DEPTH + 2));
        chk("fill_full", 32'(push_ready), 32'd0);
        popped.delete();
        gaps = 0;
        for (int i = 0; i < 20; i++) begin
            if (i < DEPTH + 2 && !pop_valid) gaps++;
            cycle(0, 32'h0, 1, 1, 1);
        end
        chk("drain_gaps", 32'(gaps), 32'd0);
        chk("drain_count", 32'(popped.size()), 32'(DEPTH + 2));
        for (int i = 0; i < popped.size(); i++) chk("drain_order", popped[i], 32'(i));
        chk("drain_empty", 32'(pop_valid), 32'd0);

        // Streaming: one word per clock after startup.
        popped.delete();
        gaps = 0;
        for (int i = 0; i < 100; i++) begin
            if (i >= 3 && !pop_valid) gaps++;
            if (i == 50) chk("stream_level", 32'(level), 32'd3);
            cycle(1, 32'h100 + 32'(i), 1, 1, 1);
        end
        for (int i = 0; i < 6; i++) cycle(0, 32'h0, 1, 1, 1);
        chk("stream_gaps", 32'(gaps), 32'd0);
        chk("stream_count", 32'(popped.size()), 32'd100);
        for (int i = 0; i < popped.size(); i++) chk("stream_order", popped[i], 32'h100 + 32'(i));

        // Reset mid-operation discards all held words.
        for (int i = 0; i < 5; i++) cycle(1, 32'hDEAD_0000 + 32'(i), 0, 1, 1);
        for (int i = 0; i < 3; i++) cycle(0, 32'h0, 0, 1, 1);
        chk("midrst_pre_level", 32'(level), 32'd5);
        cycle(0, 32'h0, 0, 0, 1);
        chk("midrst_level", 32'(level), 32'd0);
        chk("midrst_valid", 32'(pop_valid), 32'd0);
        popped.delete();
        cycle(1, 32'h1, 1, 1, 1);
        for (int i = 0; i < 6; i++) cycle(0, 32'h0, 1, 1, 1);
        chk("midrst_count", 32'(popped.size()), 32'd1);
        if (popped.size() > 0) chk("midrst_data", popped[0], 32'h1);

        // Random traffic with shifting push/pop bias and rare resets.
        pb = 50;
        rb = 50;
        for (int i = 0; i < 600; i++) begin
            if (i % 100 == 0) begin
                pb = $urandom_range(10, 95);
                rb = $urandom_range(10, 95);
            end
            cycle($urandom_range(0, 99) < pb, $urandom, $urandom_range(0, 99) < rb,
                  $urandom_range(0, 99) != 0, 1);
        end

`ifdef DPRAM_FIFO_CTRL_ERR_EN
        cycle(0, 32'h0, 0, 0, 1);
        chk("err_reset_ovf", 32'(err_ovf), 32'd0);
        for (int i = 0; i < DEPTH + 2; i++) cycle(1, $urandom, 0, 1, 1);
        chk("err_no_ovf_yet", 32'(err_ovf), 32'd0);
        cycle(1, 32'h5, 0, 1, 1);
        chk("err_ovf_set", 32'(err_ovf), 32'd1);
        cycle(0, 32'h0, 0, 1, 1);
        chk("err_ovf_sticky", 32'(err_ovf), 32'd1);
        for (int i = 0; i < DEPTH + 2; i++) cycle(0, 32'h0, 1, 1, 1);
        chk("err_no_udf_yet", 32'(err_udf), 32'd0);
        cycle(0, 32'h0, 1, 1, 1);
        chk("err_udf_set", 32'(err_udf), 32'd1);
        clr_req = 1;
        cycle(0, 32'h0, 0, 1, 1);
        clr_req = 0;
        chk("err_clr_ovf", 32'(err_ovf), 32'd0);
        chk("err_clr_udf", 32'(err_udf), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
